// File: rtl/hazard_pkg.sv
// Shared types and constants for the execute-stage hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

endpackage

// File: rtl/fwd_select.sv
// Single-operand forwarding comparator: MEM beats WB, x0 is never forwarded.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_we_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_we_i,
  output logic [1:0]            sel_c_o
);

  always_comb begin
    sel_c_o = FWD_NONE;
    if (mem_we_i && (mem_rd_i != '0) && (mem_rd_i == rs_i)) begin
      sel_c_o = FWD_MEM;
    end else if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == rs_i)) begin
      sel_c_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_hazard_controller.sv
// EX-stage hazard controller: operand forwarding, load-use stall and
// misprediction flush sequencing, plus saturating event counters.
module ex_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  misprediction_i,
  input  logic                  perf_clear_i,
  output logic [1:0]            data_a_forward_sel,
  output logic [1:0]            data_b_forward_sel,
  output logic [1:0]            data_store_forward_sel,
  output logic                  stall_o,
  output logic                  bubble_o,
  output logic                  flush_o,
  output logic [1:0]            state_o,
  output logic [CNT_W-1:0]      stall_count_o,
  output logic [CNT_W-1:0]      flush_count_o
);

  localparam int unsigned STALL_CNT_W = 2;
  localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);

  hz_state_t               state_q, state_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]        stall_count_q, stall_count_d;
  logic [CNT_W-1:0]        flush_count_q, flush_count_d;
  logic                    lu, mp;
  logic                    stall_c, bubble_c, flush_c;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs_i(ex_rs1_addr), .mem_rd_i(mem_rd_addr), .mem_we_i(mem_reg_write),
    .wb_rd_i(wb_rd_addr), .wb_we_i(wb_reg_write), .sel_c_o(data_a_forward_sel)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs_i(ex_rs2_addr), .mem_rd_i(mem_rd_addr), .mem_we_i(mem_reg_write),
    .wb_rd_i(wb_rd_addr), .wb_we_i(wb_reg_write), .sel_c_o(data_b_forward_sel)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_st (
    .rs_i(ex_rs2_addr), .mem_rd_i(mem_rd_addr), .mem_we_i(mem_reg_write),
    .wb_rd_i(wb_rd_addr), .wb_we_i(wb_reg_write), .sel_c_o(data_store_forward_sel)
  );

  assign lu = ex_valid && ex_mem_read && (ex_rd_addr != '0) &&
              ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
               (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
  assign mp = misprediction_i && ex_valid;

  // Next-state and hazard controls; FLUSH ignores mp so flushes are >= 2 cycles apart.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    stall_c     = 1'b0;
    bubble_c    = 1'b0;
    flush_c     = 1'b0;
    unique case (state_q)
      RUN, FLUSH: begin
        state_d = RUN;
        if (mp && (state_q == RUN)) begin
          flush_c = 1'b1;
          state_d = FLUSH;
        end else if (lu) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d     = STALL;
            stall_cnt_d = STALL_RELOAD;
          end
        end
      end
      STALL: begin
        if (mp) begin
          flush_c     = 1'b1;
          state_d     = FLUSH;
          stall_cnt_d = '0;
        end else begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          if (stall_cnt_q <= STALL_CNT_W'(1)) begin
            state_d     = RUN;
            stall_cnt_d = '0;
          end else begin
            stall_cnt_d = stall_cnt_q - STALL_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d     = RUN;
        stall_cnt_d = '0;
      end
    endcase
  end

  // Controls are held low while reset is asserted.
  assign stall_o  = stall_c && reset;
  assign bubble_o = bubble_c && reset;
  assign flush_o  = flush_c && reset;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (perf_clear_i) begin
      stall_count_d = '0;
      flush_count_d = '0;
    end else begin
      if (stall_o && !(&stall_count_q)) stall_count_d = stall_count_q + CNT_W'(1);
      if (flush_o && !(&flush_count_q)) flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      stall_cnt_q   <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign state_o       = state_q;
  assign stall_count_o = stall_count_q;
  assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Bench for ex_hazard_controller: dut_a (2-cycle stall, 4-bit counters) and
// dut_b (3-cycle stall, 32-bit counters) share one set of inputs.
module tb_ex_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr;
  logic [4:0] ex_rd_addr, mem_rd_addr, wb_rd_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read;
  logic       mem_reg_write, wb_reg_write, misprediction_i, perf_clear_i;

  logic [1:0]  a_fa, a_fb, a_fs, a_state, b_fa, b_fb, b_fs, b_state;
  logic        a_stall, a_bubble, a_flush, b_stall, b_bubble, b_flush;
  logic [3:0]  a_scnt, a_fcnt;
  logic [31:0] b_scnt, b_fcnt;

  always #5 clk = ~clk;

  ex_hazard_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(2), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .misprediction_i(misprediction_i), .perf_clear_i(perf_clear_i),
    .data_a_forward_sel(a_fa), .data_b_forward_sel(a_fb), .data_store_forward_sel(a_fs),
    .stall_o(a_stall), .bubble_o(a_bubble), .flush_o(a_flush), .state_o(a_state),
    .stall_count_o(a_scnt), .flush_count_o(a_fcnt)
  );

  ex_hazard_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .mem_rd_addr(mem_rd_addr), .wb_rd_addr(wb_rd_addr),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .misprediction_i(misprediction_i), .perf_clear_i(perf_clear_i),
    .data_a_forward_sel(b_fa), .data_b_forward_sel(b_fb), .data_store_forward_sel(b_fs),
    .stall_o(b_stall), .bubble_o(b_bubble), .flush_o(b_flush), .state_o(b_state),
    .stall_count_o(b_scnt), .flush_count_o(b_fcnt)
  );

  typedef enum int {S_FA, S_FB, S_FS, S_STALL, S_BUBBLE, S_FLUSH, S_STATE, S_SCNT, S_FCNT,
                    S_B_STATE, S_B_STALL, S_B_BUBBLE, S_B_SCNT, S_B_FCNT, S_B_FA} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic [4:0] rs1, rs2, mem_rd, wb_rd;
    logic       mem_we, wb_we;
    logic [1:0] exp_a, exp_b;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_FA:       return 32'(a_fa);
      S_FB:       return 32'(a_fb);
      S_FS:       return 32'(a_fs);
      S_STALL:    return 32'(a_stall);
      S_BUBBLE:   return 32'(a_bubble);
      S_FLUSH:    return 32'(a_flush);
      S_STATE:    return 32'(a_state);
      S_SCNT:     return 32'(a_scnt);
      S_FCNT:     return 32'(a_fcnt);
      S_B_STATE:  return 32'(b_state);
      S_B_STALL:  return 32'(b_stall);
      S_B_BUBBLE: return 32'(b_bubble);
      S_B_SCNT:   return b_scnt;
      S_B_FCNT:   return b_fcnt;
      S_B_FA:     return 32'(b_fa);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_sig(input string name, input sig_e s, input logic [31:0] v);
    sb.push_back('{name, s, v});
  endtask

  task automatic drain();
    sb_t e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = sample(e.sig);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", e.name, act, e.exp, $time);
      end
    end
  endtask

  // Compare at the falling edge, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1_addr = '0; ex_rs2_addr = '0; ex_valid = 1'b0; ex_rd_addr = '0;
    ex_mem_read = 1'b0; mem_rd_addr = '0; wb_rd_addr = '0;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    misprediction_i = 1'b0; perf_clear_i = 1'b0;
  endtask

  task automatic drive_lu();
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd7;
    id_rs2_addr = 5'd7; id_uses_rs2 = 1'b1;
  endtask

  initial begin
    vecs[0] = '{5'd5,  5'd3,  5'd5,  5'd5,  1'b1, 1'b1, 2'b01, 2'b00};
    vecs[1] = '{5'd5,  5'd5,  5'd5,  5'd5,  1'b0, 1'b1, 2'b10, 2'b10};
    vecs[2] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 2'b00, 2'b00};
    vecs[3] = '{5'd9,  5'd9,  5'd9,  5'd9,  1'b1, 1'b1, 2'b01, 2'b01};
    vecs[4] = '{5'd31, 5'd4,  5'd4,  5'd31, 1'b1, 1'b1, 2'b10, 2'b01};
    vecs[5] = '{5'd7,  5'd7,  5'd7,  5'd7,  1'b0, 1'b0, 2'b00, 2'b00};
    vecs[6] = '{5'd12, 5'd13, 5'd13, 5'd12, 1'b1, 1'b0, 2'b00, 2'b01};

    // Reset: controls forced low even with hazards present, forwarding still live.
    idle();
    reset = 1'b0;
    drive_lu();
    misprediction_i = 1'b1;
    ex_rs1_addr = 5'd5; mem_rd_addr = 5'd5; mem_reg_write = 1'b1;
    #2;
    expect_sig("rst_fwd_a", S_FA, 32'd1);
    expect_sig("rst_stall", S_STALL, 32'd0);
    expect_sig("rst_bubble", S_BUBBLE, 32'd0);
    expect_sig("rst_flush", S_FLUSH, 32'd0);
    expect_sig("rst_state", S_STATE, 32'd0);
    expect_sig("rst_scnt", S_SCNT, 32'd0);
    expect_sig("rst_fcnt", S_FCNT, 32'd0);
    tick();
    tick();
    idle();
    reset = 1'b1;
    tick();

    // Forwarding table.
    for (int i = 0; i < 7; i++) begin
      idle();
      ex_rs1_addr = vecs[i].rs1; ex_rs2_addr = vecs[i].rs2;
      mem_rd_addr = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_we;
      wb_rd_addr = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_we;
      expect_sig($sformatf("fwd_a[%0d]", i), S_FA, 32'(vecs[i].exp_a));
      expect_sig($sformatf("fwd_b[%0d]", i), S_FB, 32'(vecs[i].exp_b));
      expect_sig($sformatf("fwd_st[%0d]", i), S_FS, 32'(vecs[i].exp_b));
      expect_sig($sformatf("fwd_stall[%0d]", i), S_STALL, 32'd0);
      tick();
    end

    // Load-use via rs2: exactly two stall cycles on dut_a.
    idle(); drive_lu();
    expect_sig("lu0_stall", S_STALL, 32'd1);
    expect_sig("lu0_bubble", S_BUBBLE, 32'd1);
    expect_sig("lu0_state", S_STATE, 32'd0);
    expect_sig("lu0_b_stall", S_B_STALL, 32'd1);
    tick();
    idle();
    expect_sig("lu1_stall", S_STALL, 32'd1);
    expect_sig("lu1_bubble", S_BUBBLE, 32'd1);
    expect_sig("lu1_state", S_STATE, 32'd1);
    expect_sig("lu1_scnt", S_SCNT, 32'd1);
    tick();
    expect_sig("lu2_stall", S_STALL, 32'd0);
    expect_sig("lu2_state", S_STATE, 32'd0);
    expect_sig("lu2_scnt", S_SCNT, 32'd2);
    expect_sig("lu2_b_state", S_B_STATE, 32'd1);
    tick();

    // No hazard when rs2 is unused or the load targets x0.
    idle(); drive_lu(); id_uses_rs2 = 1'b0;
    expect_sig("nolu_unused", S_STALL, 32'd0);
    tick();
    idle(); drive_lu(); ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
    expect_sig("nolu_x0", S_STALL, 32'd0);
    tick();

    // Misprediction beats load-use; held misprediction does not flush twice.
    idle(); drive_lu(); misprediction_i = 1'b1;
    expect_sig("mp_flush", S_FLUSH, 32'd1);
    expect_sig("mp_stall", S_STALL, 32'd0);
    expect_sig("mp_bubble", S_BUBBLE, 32'd0);
    tick();
    idle(); ex_valid = 1'b1; misprediction_i = 1'b1;
    expect_sig("fl_state", S_STATE, 32'd2);
    expect_sig("fl_flush", S_FLUSH, 32'd0);
    expect_sig("fl_fcnt", S_FCNT, 32'd1);
    tick();
    idle();
    expect_sig("fl_after_state", S_STATE, 32'd0);
    expect_sig("fl_after_fcnt", S_FCNT, 32'd1);
    tick();

    // Load-use evaluated in FLUSH enters a full stall.
    idle(); drive_lu(); misprediction_i = 1'b1;
    expect_sig("mp2_flush", S_FLUSH, 32'd1);
    tick();
    expect_sig("fllu_state", S_STATE, 32'd2);
    expect_sig("fllu_stall", S_STALL, 32'd1);
    expect_sig("fllu_flush", S_FLUSH, 32'd0);
    expect_sig("fllu_fcnt", S_FCNT, 32'd2);
    tick();
    idle();
    expect_sig("fllu_st_state", S_STATE, 32'd1);
    expect_sig("fllu_st_stall", S_STALL, 32'd1);
    expect_sig("fllu_st_scnt", S_SCNT, 32'd3);
    tick();
    expect_sig("fllu_end_stall", S_STALL, 32'd0);
    expect_sig("fllu_end_scnt", S_SCNT, 32'd4);
    tick();

    // Saturation of the 4-bit stall counter, then clear beats increment.
    idle(); drive_lu();
    for (int i = 0; i < 14; i++) tick();
    expect_sig("sat_stall", S_STALL, 32'd1);
    expect_sig("sat_scnt", S_SCNT, 32'd15);
    tick();
    expect_sig("sat_hold", S_SCNT, 32'd15);
    perf_clear_i = 1'b1;
    expect_sig("clr_stall", S_STALL, 32'd1);
    tick();
    perf_clear_i = 1'b0;
    expect_sig("clr_scnt", S_SCNT, 32'd0);
    expect_sig("clr_fcnt", S_FCNT, 32'd0);
    tick();
    idle();
    for (int i = 0; i < 6; i++) tick();

    // Reset asserted mid-stall on dut_b; restart in RUN with clean counters.
    drive_lu();
    expect_sig("rs_b_stall0", S_B_STALL, 32'd1);
    expect_sig("rs_b_state0", S_B_STATE, 32'd0);
    tick();
    idle();
    expect_sig("rs_b_state1", S_B_STATE, 32'd1);
    expect_sig("rs_b_stall1", S_B_STALL, 32'd1);
    @(negedge clk);
    drain();
    reset = 1'b0;
    drive_lu();
    #1;
    expect_sig("rs_b_state_now", S_B_STATE, 32'd0);
    expect_sig("rs_b_stall_now", S_B_STALL, 32'd0);
    expect_sig("rs_b_bubble_now", S_B_BUBBLE, 32'd0);
    expect_sig("rs_a_stall_now", S_STALL, 32'd0);
    drain();
    @(posedge clk);
    @(posedge clk);
    #1;
    idle();
    reset = 1'b1;
    expect_sig("rel_b_state", S_B_STATE, 32'd0);
    expect_sig("rel_b_stall", S_B_STALL, 32'd0);
    expect_sig("rel_b_scnt", S_B_SCNT, 32'd0);
    expect_sig("rel_b_fcnt", S_B_FCNT, 32'd0);
    expect_sig("rel_a_scnt", S_SCNT, 32'd0);
    tick();
    expect_sig("rel2_b_state", S_B_STATE, 32'd0);
    expect_sig("rel2_b_stall", S_B_STALL, 32'd0);
    expect_sig("rel2_b_scnt", S_B_SCNT, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_hazard_controller.md
# ex_hazard_controller

Pipeline hazard controller for the execute stage. Generates the three EX operand-forwarding selects and sequences load-use stalls and branch-misprediction flushes for the front end. Free-running saturating performance counters record both events. Sits beside the execute stage in the core top level; its outputs drive the EX forwarding muxes, the PC/IF-ID hold enables and the ID/EX bubble/flush controls.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- LOAD_STALL_CYCLES, 1, stall length per load-use hazard; legal range 1..3
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  core clock; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  ID-stage source registers
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads that source
- ex_rs1_addr, ex_rs2_addr  in  REG_ADDR_W  EX-stage source registers
- ex_valid  in  1  EX holds a real (non-bubble) instruction
- ex_rd_addr  in  REG_ADDR_W  EX destination
- ex_mem_read  in  1  EX instruction is a load
- mem_rd_addr, wb_rd_addr  in  REG_ADDR_W  MEM/WB destinations
- mem_reg_write, wb_reg_write  in  1  MEM/WB write the register file
- misprediction_i  in  1  EX branch-resolution mismatch
- perf_clear_i  in  1  synchronous clear of both counters
- data_a_forward_sel, data_b_forward_sel, data_store_forward_sel  out  2  00 = pipeline value, 01 = MEM result, 10 = WB result; 11 is never driven
- stall_o  out  1  hold PC and IF/ID
- bubble_o  out  1  load a NOP into ID/EX
- flush_o  out  1  kill IF/ID and ID/EX contents at the next edge
- state_o  out  2  current FSM state
- stall_count_o, flush_count_o  out  CNT_W  performance counters

## Operation
- Forwarding (combinational):
  - A-select compares ex_rs1_addr; B-select and store-select both compare ex_rs2_addr.
  - MEM match (mem_reg_write, rd ≠ 0, addresses equal) → 01.
  - Otherwise, WB match under the same rule → 10.
  - Otherwise → 00. MEM has priority over WB. x0 is never forwarded.
- Load-use hazard (lu): ex_valid & ex_mem_read & ex_rd_addr ≠ 0 & ((id_uses_rs1 & id_rs1_addr == ex_rd_addr) | (id_uses_rs2 & id_rs2_addr == ex_rd_addr)).
- Accepted misprediction (mp): misprediction_i & ex_valid.
- FSM states (hazard_pkg::hz_state_t): RUN = 00, STALL = 01, FLUSH = 10.
  - RUN, mp: flush_o = 1, stall_o = 0, bubble_o = 0; next state FLUSH. mp has priority over lu in the same cycle.
  - RUN, lu and no mp: stall_o = 1, bubble_o = 1. If LOAD_STALL_CYCLES > 1, next state STALL and the remaining-cycle counter is loaded with LOAD_STALL_CYCLES − 1; otherwise stay in RUN.
  - STALL: stall_o = 1, bubble_o = 1, counter decrements each cycle; at count 1 return to RUN. lu is not re-evaluated in STALL. mp in STALL (not expected, since EX holds a bubble) aborts the stall: flush_o = 1, next state FLUSH.
  - FLUSH: one cycle. misprediction_i is ignored, flush_o = 0, lu is evaluated exactly as in RUN. Next state is RUN, or STALL if lu triggers a multi-cycle stall.
- Counters:
  - stall_count_o increments every cycle stall_o = 1.
  - flush_count_o increments every cycle flush_o = 1.
  - Both saturate at all-ones.
  - perf_clear_i zeroes both and overrides an increment in the same cycle.

## Timing
- Forward selects, stall_o, bubble_o and flush_o are combinational from the current inputs and state, with zero latency, so they take effect at the next rising edge.
- state_o, the stall counter and the performance counters are registered on posedge clk.
- Reset asserted: state = RUN, stall counter = 0, stall_count_o = 0, flush_count_o = 0, state_o = 00. stall_o, bubble_o and flush_o are forced to 0 during reset; forward selects still follow their inputs.
- Reset deasserted mid-STALL or mid-FLUSH: the controller restarts in RUN with no residual stall.
- Total stall length per load-use hazard is exactly LOAD_STALL_CYCLES cycles.
- Minimum spacing between two accepted flushes is 2 cycles.

## Structure
- hazard_pkg holds:
  - hz_state_t enum.
  - Forward-select constants FWD_NONE = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10.
- Sub-module fwd_select: a combinational single-operand priority comparator (rs, MEM rd/we, WB rd/we → 2-bit select), instantiated three times.
- FSM, stall counter and performance counters live in ex_hazard_controller.

## Test plan
- MEM and WB both write x5, ex_rs1_addr = 5 → data_a_forward_sel = 01. Then mem_reg_write = 0 → 10. Then ex_rs1_addr = 0 with both rd = 0 → 00.
- EX load to x7, ID reads x7 via rs2, LOAD_STALL_CYCLES = 2 → stall_o = bubble_o = 1 for exactly 2 cycles, state_o = 01 in the second cycle, stall_count_o = 2.
- Same load-use case with id_uses_rs2 = 0, or ex_rd_addr = 0 → no stall.
- misprediction_i and lu in the same cycle → flush_o = 1, stall_o = 0, state FLUSH next cycle. misprediction_i held high into FLUSH → no second flush, flush_count_o = 1.
- Preload stall_count_o to all-ones via a long stall run with CNT_W = 4 → the counter holds at 15. Assert perf_clear_i together with a stall → counter reads 0.
- Assert reset during STALL with LOAD_STALL_CYCLES = 3 → state_o = 00, stall_o = 0 immediately, all counters 0 after release.
